// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin sharing of one start/done fp_adder among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining FPA_ARB_TIMEOUT_EN.
module fp_adder_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  output logic                      add_start,
  input  logic [DATA_W-1:0]         add_result,
  input  logic                      add_done,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int                 IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]     NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]  QNAN      = DATA_W'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] grant_idx_d;
  logic             grant_vld_d;
  logic [IDX_W:0]   cand_d;
  logic [IDX_W-1:0] ptr_next_d;
  logic             tmo_hit_d;

  // Round-robin search: first pending requester at ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = '0;
    cand_d      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_d = {1'b0, ptr_q} + (IDX_W+1)'(k);
      cand_d = (cand_d >= NUM_REQ_W) ? (cand_d - NUM_REQ_W) : cand_d;
      if (!grant_vld_d && req_valid[cand_d[IDX_W-1:0]]) begin
        grant_vld_d = 1'b1;
        grant_idx_d = cand_d[IDX_W-1:0];
      end else begin
        grant_idx_d = grant_idx_d;
      end
    end
  end

  assign ptr_next_d = (gnt_q == LAST_IDX) ? '0 : (gnt_q + IDX_W'(1));

`ifdef FPA_ARB_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;

  assign tmo_hit_d   = (state_q == ST_WAIT) && (tmo_cnt_q == TMO_LAST);
  assign timeout_err = tmo_err_q;

  // Watchdog: counts WAIT cycles of the current op; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_WAIT && !add_done && !tmo_hit_d) begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
      if (tmo_hit_d && !add_done) begin
        tmo_err_q <= 1'b1;
      end
    end
  end
`else
  // Watchdog disabled; TIMEOUT_CYCLES only keeps the parameter list build-independent.
  assign tmo_hit_d   = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      add_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            add_a     <= req_a[int'(grant_idx_d)*DATA_W +: DATA_W];
            add_b     <= req_b[int'(grant_idx_d)*DATA_W +: DATA_W];
            req_ready <= ONE_HOT0 << grant_idx_d;
            gnt_q     <= grant_idx_d;
            busy      <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          add_start <= 1'b1;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (add_done) begin
            rsp_result <= add_result;
            rsp_valid  <= ONE_HOT0 << gnt_q;
            ptr_q      <= ptr_next_d;
            busy       <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (tmo_hit_d) begin
            rsp_result <= QNAN;
            rsp_valid  <= ONE_HOT0 << gnt_q;
            ptr_q      <= ptr_next_d;
            busy       <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Bench for fp_adder_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model and a stand-in adder.
module tb_fp_adder_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [W-1:0]   rsp_result, add_a, add_b, add_result;
  logic           add_start, add_done, busy, timeout_err;

  fp_adder_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_result(add_result),
    .add_done(add_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side drive state
  logic [N-1:0] drv_valid;
  logic [W-1:0] drv_a [N];
  logic [W-1:0] drv_b [N];
  logic         drv_done;
  logic [W-1:0] drv_res;
  // Transaction-level reference model
  int           ptr_m, owner_m, done_cnt, wait_edges;
  bit           free_m, start_due, waiting_m, tmo_m;
  logic [W-1:0] own_a, own_b;
  // Stimulus policy
  bit           rand_mode, adder_auto, force_done, fixed_ops;
  logic [N-1:0] reissue;
  logic [W-1:0] fix_a, fix_b;
  // Observed-output logs
  int           grant_log[$];
  logic [N-1:0] rsp_log[$];
  logic [W-1:0] res_log[$];
  int           start_cnt;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin idx = i; cnt++; end
    return (cnt == 1) ? idx : -1;
  endfunction

  // Stand-in adder: exact sums for the directed operands, a deterministic mix otherwise.
  function automatic logic [W-1:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h3F00_0000 && b == 32'h3F80_0000) return 32'h3FC0_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic apply_inputs();
    req_valid = drv_valid;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = drv_a[i];
      req_b[i*W +: W] = drv_b[i];
    end
    add_done   = drv_done;
    add_result = drv_res;
  endtask

  task automatic new_ops(input int i);
    drv_a[i] = fixed_ops ? fix_a : $urandom();
    drv_b[i] = fixed_ops ? fix_b : $urandom();
  endtask

  task automatic model_reset();
    ptr_m = 0; owner_m = 0; done_cnt = -1; wait_edges = 0;
    free_m = 1'b1; start_due = 1'b0; waiting_m = 1'b0; tmo_m = 1'b0;
    own_a = '0; own_b = '0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); rsp_log.delete(); res_log.delete(); start_cnt = 0;
  endtask

  // One clock: check outputs of the last edge against the model, then drive next inputs.
  task automatic step();
    logic [N-1:0] exp_ready, exp_rsp;
    logic [W-1:0] exp_res;
    int g;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_add_start", add_start, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      model_reset();
      drv_done = 1'b0;
    end else begin
      g = -1; exp_ready = '0; exp_rsp = '0; exp_res = '0;
      if (free_m && drv_valid != '0) begin
        g = pick(drv_valid, ptr_m);
        exp_ready[g] = 1'b1;
      end
      if (waiting_m) begin
        wait_edges++;
        if (drv_done) begin
          exp_rsp[owner_m] = 1'b1; exp_res = drv_res;
        end
`ifdef FPA_ARB_TIMEOUT_EN
        else if (wait_edges == TMO) begin
          exp_rsp[owner_m] = 1'b1; exp_res = 32'h7FC0_0000; tmo_m = 1'b1;
        end
`endif
      end
      check("req_ready", req_ready, exp_ready);
      check("add_start", add_start, start_due);
      check("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != '0) check("rsp_result", rsp_result, exp_res);
      if (req_ready != '0) grant_log.push_back(onehot_idx(req_ready));
      if (rsp_valid != '0) begin rsp_log.push_back(rsp_valid); res_log.push_back(rsp_result); end
      if (add_start) start_cnt++;
      if (exp_rsp != '0) begin waiting_m = 1'b0; free_m = 1'b1; ptr_m = (owner_m + 1) % N; end
      if (start_due) begin
        check("start_add_a", add_a, own_a);
        check("start_add_b", add_b, own_b);
        start_due = 1'b0; waiting_m = 1'b1; wait_edges = 0;
        done_cnt = adder_auto ? int'($urandom_range(0, 4)) : -1;
      end
      if (g >= 0) begin
        free_m = 1'b0; owner_m = g; own_a = drv_a[g]; own_b = drv_b[g]; start_due = 1'b1;
        check("grant_add_a", add_a, own_a);
      end
      check("busy", busy, !free_m);
      check("timeout_err", timeout_err, tmo_m);
      // adder model drive
      drv_done = 1'b0;
      drv_res  = $urandom();
      if (done_cnt == 0 || force_done) begin
        drv_done = 1'b1; drv_res = adder_model(own_a, own_b); done_cnt = -1;
      end else if (done_cnt > 0) begin
        done_cnt--;
      end
      force_done = 1'b0;
      // requester drive
      if (g >= 0) begin
        if (reissue[g] || (rand_mode && $urandom_range(0, 1) == 0)) new_ops(g);
        else drv_valid[g] = 1'b0;
      end
      if (rand_mode) begin
        for (int i = 0; i < N; i++) begin
          if (i != g) begin
            if (!drv_valid[i]) begin
              if ($urandom_range(0, 3) == 0) begin drv_valid[i] = 1'b1; new_ops(i); end
            end else if ($urandom_range(0, 15) == 0) begin
              drv_valid[i] = 1'b0;
            end
          end
        end
      end
    end
    apply_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until_rsp(input int cnt, input int budget, input string tag);
    int k = 0;
    while (rsp_log.size() < cnt && k < budget) begin step(); k++; end
    check(tag, rsp_log.size(), cnt);
  endtask

  task automatic run_until_start(input int budget, input string tag);
    int k = 0;
    while (start_cnt < 1 && k < budget) begin step(); k++; end
    check(tag, start_cnt, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; drv_valid = '0; drv_done = 1'b0; force_done = 1'b0; reissue = '0;
    apply_inputs();
    run(2);
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    rst_n = 1'b0; drv_valid = '0; drv_done = 1'b0; drv_res = '0;
    for (int i = 0; i < N; i++) begin drv_a[i] = '0; drv_b[i] = '0; end
    rand_mode = 1'b0; adder_auto = 1'b1; force_done = 1'b0; fixed_ops = 1'b0; reissue = '0;
    fix_a = 32'h3F00_0000; fix_b = 32'h3F80_0000;
    model_reset(); clear_logs(); apply_inputs();
    run(2);
    rst_n = 1'b1;

    // single request
    drv_valid = 4'b0001; drv_a[0] = 32'h3F80_0000; drv_b[0] = 32'h4000_0000; apply_inputs();
    run_until_rsp(1, 40, "t1_rsp_seen");
    run(3);
    check("t1_grant_count", grant_log.size(), 1);
    check("t1_grant_idx", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check("t1_start_count", start_cnt, 1);
    check("t1_rsp_valid", rsp_log.size() > 0 ? rsp_log[0] : 4'b0000, 4'b0001);
    check("t1_result", res_log.size() > 0 ? res_log[0] : 32'h0, 32'h4040_0000);

    // all four requesters pending with identical operands
    do_reset();
    fixed_ops = 1'b1;
    drv_valid = 4'b1111;
    for (int i = 0; i < N; i++) new_ops(i);
    apply_inputs();
    run_until_rsp(4, 100, "t2_rsp_seen");
    for (int k = 0; k < 4; k++) begin
      check("t2_grant_order", grant_log.size() > k ? grant_log[k] : -1, k);
      check("t2_rsp_onehot", rsp_log.size() > k ? rsp_log[k] : 4'b0000, 4'b0001 << k);
      check("t2_result", res_log.size() > k ? res_log[k] : 32'h0, 32'h3FC0_0000);
    end
    fixed_ops = 1'b0;

    // fairness: requesters 0 and 2 held continuously
    do_reset();
    reissue = 4'b0101; drv_valid = 4'b0101; new_ops(0); new_ops(2); apply_inputs();
    run_until_rsp(8, 200, "t3_rsp_seen");
    for (int k = 0; k < 8; k++)
      check("t3_alternate", grant_log.size() > k ? grant_log[k] : -1, (k % 2) * 2);

    // reset during WAIT
    do_reset();
    adder_auto = 1'b0;
    drv_valid = 4'b0001; new_ops(0); apply_inputs();
    run_until_start(10, "t4_start_seen");
    step();
    rst_n = 1'b0; drv_valid = '0; apply_inputs();
    #1;
    check("t4_async_busy", busy, 0);
    check("t4_async_add_a", add_a, 0);
    run(2);
    rst_n = 1'b1;
    clear_logs();
    force_done = 1'b1;
    run(3);
    check("t4_stray_done_rsp", rsp_log.size(), 0);
    drv_valid = 4'b1010; new_ops(1); new_ops(3); apply_inputs();
    adder_auto = 1'b1;
    run_until_rsp(1, 40, "t4_rsp_seen");
    check("t4_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    check("t4_rsp_valid", rsp_log.size() > 0 ? rsp_log[0] : 4'b0000, 4'b0010);

    // withdrawn request, then a stray done while idle
    do_reset();
    adder_auto = 1'b0;
    drv_valid = 4'b0001; new_ops(0); apply_inputs();
    run_until_start(10, "t5_start_seen");
    drv_valid[1] = 1'b1; new_ops(1); apply_inputs();
    run(3);
    drv_valid[1] = 1'b0; apply_inputs();
    run(2);
    force_done = 1'b1;
    run(4);
    force_done = 1'b1;
    run(4);
    check("t5_rsp_count", rsp_log.size(), 1);
    check("t5_rsp_owner", rsp_log.size() > 0 ? rsp_log[0] : 4'b0000, 4'b0001);
    check("t5_grant_count", grant_log.size(), 1);
    adder_auto = 1'b1;

`ifdef FPA_ARB_TIMEOUT_EN
    // watchdog with an adder that never answers
    do_reset();
    adder_auto = 1'b0;
    drv_valid = 4'b0001; new_ops(0); apply_inputs();
    run(TMO + 8);
    check("t6_tmo_rsp_count", rsp_log.size(), 1);
    check("t6_tmo_result", res_log.size() > 0 ? res_log[0] : 32'h0, 32'h7FC0_0000);
    check("t6_tmo_err", timeout_err, 1);
    adder_auto = 1'b1;
    drv_valid = 4'b0100; new_ops(2); apply_inputs();
    run_until_rsp(2, 40, "t6_next_rsp_seen");
    check("t6_next_owner", rsp_log.size() > 1 ? rsp_log[1] : 4'b0000, 4'b0100);
    check("t6_tmo_err_sticky", timeout_err, 1);
`endif

    // randomized traffic, then drain
    do_reset();
    rand_mode = 1'b1;
    run(3000);
    rand_mode = 1'b0; drv_valid = '0; apply_inputs();
    run(20);
    check("rand_all_answered", rsp_log.size(), grant_log.size());
    check("rand_traffic_seen", grant_log.size() > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
